// File: rtl/axi_wr_req_packer.sv
// Serialises AXI4 AW/W bursts into header + data-beat words for the clock-crossing FIFO.
// The single output register is loaded only when it is empty or being drained in the same cycle.
module axi_wr_req_packer #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int ID_W   = 4,
    parameter int PAY_W  = ((ID_W + ADDR_W + 13) > (DATA_W + DATA_W / 8 + 1)) ?
                           (ID_W + ADDR_W + 13) : (DATA_W + DATA_W / 8 + 1),
    parameter int OUT_W  = PAY_W + 1
) (
    input  logic                  WCLK,
    input  logic                  WRESETn,
    input  logic [ID_W-1:0]       AWID,
    input  logic [ADDR_W-1:0]     AWADDR,
    input  logic [7:0]            AWLEN,
    input  logic [2:0]            AWSIZE,
    input  logic [1:0]            AWBURST,
    input  logic                  AWVALID,
    output logic                  AWREADY,
    input  logic [DATA_W-1:0]     WDATA,
    input  logic [DATA_W/8-1:0]   WSTRB,
    input  logic                  WLAST,
    input  logic                  WVALID,
    output logic                  WREADY,
    output logic [OUT_W-1:0]      O_DATA,
    output logic                  O_VALID,
    input  logic                  O_READY,
    output logic                  ERR,
    input  logic                  ERR_CLR
);

    localparam int STRB_W = DATA_W / 8;
    localparam int HDR_W  = ID_W + ADDR_W + 13;
    localparam int DAT_W  = DATA_W + STRB_W + 1;

    typedef enum logic [1:0] {IDLE, DATA, DRAIN} state_t;

    state_t             state_q;
    state_t             state_d;
    logic [7:0]         len_q;
    logic [7:0]         cnt_q;
    logic               run_q;
    logic               err_q;
    logic               vld_p1;
    logic [OUT_W-1:0]   data_p1;

    logic               slot_free;
    logic               aw_hs;
    logic               w_hs;
    logic               load_hdr;
    logic               load_dat;
    logic               at_end;
    logic               last_bit;
    logic               err_set;

    function automatic logic [OUT_W-1:0] pack_hdr(
        input logic [ID_W-1:0]   id,
        input logic [ADDR_W-1:0] addr,
        input logic [7:0]        len,
        input logic [2:0]        size,
        input logic [1:0]        burst
    );
        logic [OUT_W-1:0] w;
        w            = '0;
        w[OUT_W-1]   = 1'b1;
        w[HDR_W-1:0] = {id, addr, len, size, burst};
        return w;
    endfunction

    function automatic logic [OUT_W-1:0] pack_dat(
        input logic              last,
        input logic [STRB_W-1:0] strb,
        input logic [DATA_W-1:0] data
    );
        logic [OUT_W-1:0] w;
        w            = '0;
        w[DAT_W-1:0] = {last, strb, data};
        return w;
    endfunction

    assign slot_free = !vld_p1 || O_READY;
    assign aw_hs     = AWVALID && AWREADY;
    assign w_hs      = WVALID && WREADY;
    assign load_hdr  = aw_hs;
    assign load_dat  = w_hs && (state_q == DATA);
    assign at_end    = (cnt_q == len_q);
    // A burst that reaches its length without WLAST still closes with last=1 downstream.
    assign last_bit  = at_end || WLAST;
    assign err_set   = load_dat && (WLAST != at_end);

    // run_q keeps both readies low while reset is held and for the first cycle after release.
    always_ff @(posedge WCLK or negedge WRESETn) begin
        if (!WRESETn) begin
            state_q <= IDLE;
            run_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            run_q   <= 1'b1;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (aw_hs) state_d = DATA;
            end
            DATA: begin
                if (w_hs) begin
                    if (WLAST)       state_d = IDLE;
                    else if (at_end) state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (w_hs && WLAST) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        AWREADY = 1'b0;
        WREADY  = 1'b0;
        case (state_q)
            IDLE:    AWREADY = run_q && slot_free;
            DATA:    WREADY  = run_q && slot_free;
            DRAIN:   WREADY  = run_q;
            default: ;
        endcase
    end

    always_ff @(posedge WCLK or negedge WRESETn) begin
        if (!WRESETn) begin
            len_q <= 8'd0;
            cnt_q <= 8'd0;
        end else if (load_hdr) begin
            len_q <= AWLEN;
            cnt_q <= 8'd0;
        end else if (load_dat && !last_bit) begin
            cnt_q <= cnt_q + 8'd1;
        end
    end

    always_ff @(posedge WCLK or negedge WRESETn) begin
        if (!WRESETn) begin
            err_q <= 1'b0;
        end else if (err_set) begin
            err_q <= 1'b1;
        end else if (ERR_CLR) begin
            err_q <= 1'b0;
        end
    end

    // Stage p1: FIFO word register, held while the FIFO is full.
    always_ff @(posedge WCLK or negedge WRESETn) begin
        if (!WRESETn) begin
            vld_p1  <= 1'b0;
            data_p1 <= '0;
        end else if (load_hdr) begin
            vld_p1  <= 1'b1;
            data_p1 <= pack_hdr(AWID, AWADDR, AWLEN, AWSIZE, AWBURST);
        end else if (load_dat) begin
            vld_p1  <= 1'b1;
            data_p1 <= pack_dat(last_bit, WSTRB, WDATA);
        end else if (O_READY) begin
            vld_p1  <= 1'b0;
        end
    end

    assign O_DATA  = data_p1;
    assign O_VALID = vld_p1;
    assign ERR     = err_q;

endmodule

// File: doc/axi_wr_req_packer.md
Name: axi_wr_req_packer

Overview:
- Sits in the WCLK domain directly upstream of the asynchronous clock-crossing FIFO.
- Accepts the AXI4 write-address (AW) and write-data (W) channels of one slave port.
- Serialises each burst into a stream of FIFO words: one header word, then one word per data beat.
- Drives the FIFO write side (O_DATA/O_VALID/O_READY). The far domain rebuilds the burst from this stream.

Parameters:
- ADDR_W, 32, AWADDR width.
- DATA_W, 32, WDATA width; must be a multiple of 8.
- ID_W, 4, AWID width.
- PAY_W, max(ID_W+ADDR_W+13, DATA_W+DATA_W/8+1), payload width (default 49).
- OUT_W, PAY_W+1, FIFO word width (default 50); must equal the FIFO WIDTH.

Ports:
- WCLK  in  1  clock.
- WRESETn  in  1  reset.
- AWID  in  ID_W  burst id.
- AWADDR  in  ADDR_W  start address.
- AWLEN  in  8  beats-1.
- AWSIZE  in  3  beat size.
- AWBURST  in  2  burst type.
- AWVALID  in  1  AW valid.
- AWREADY  out  1  AW ready.
- WDATA  in  DATA_W  write data.
- WSTRB  in  DATA_W/8  byte strobes.
- WLAST  in  1  last beat.
- WVALID  in  1  W valid.
- WREADY  out  1  W ready.
- O_DATA  out  OUT_W  FIFO word.
- O_VALID  out  1  FIFO word valid.
- O_READY  in  1  FIFO not full.
- ERR  out  1  sticky WLAST-mismatch flag.
- ERR_CLR  in  1  synchronous clear of ERR.

Behaviour:
- Interface: reset WRESETn, asynchronous, active-low; clock WCLK.
- Reset values: state=IDLE, O_VALID=0, O_DATA=0, beat counter=0, ERR=0, AWREADY=0, WREADY=0.
- Output register:
  - Single stage. slot_free = !O_VALID || O_READY.
  - A word is loaded on the cycle its input handshake completes and appears on O_DATA/O_VALID the next cycle (latency 1).
  - O_VALID/O_DATA hold stable until O_READY=1. O_VALID clears when O_READY=1 and no new load occurs.
  - Full throughput: one word per cycle while O_READY stays 1.
- Word formats:
  - Header: O_DATA[OUT_W-1]=1; low bits = {AWID, AWADDR, AWLEN, AWSIZE, AWBURST}, zero-extended to PAY_W.
  - Data: O_DATA[OUT_W-1]=0; low bits = {last, WSTRB, WDATA}, zero-extended.
- FSM IDLE:
  - AWREADY = slot_free; WREADY = 0.
  - On AW handshake: load header, latch AWLEN into len, clear beat counter, go to DATA.
- FSM DATA:
  - WREADY = slot_free; AWREADY = 0.
  - On W handshake: load data word, increment counter.
  - Beat counter == len and WLAST=1: last=1, go to IDLE.
  - Beat counter < len and WLAST=1 (early last): last=1, ERR<=1, go to IDLE.
  - Beat counter == len and WLAST=0 (late last): last forced to 1, ERR<=1, go to DRAIN.
  - Otherwise: last=0, stay in DATA.
- FSM DRAIN:
  - WREADY = 1; AWREADY = 0. Nothing is written to the FIFO.
  - W beats are discarded until a beat with WLAST=1 is accepted, then go to IDLE.
- Back-to-back bursts: the header of burst N+1 may load on the cycle after the last beat of burst N. No bubble is required beyond slot_free.
- AWLEN=255 gives 256 beats. The counter is 8 bits and compares against len without overflow.
- ERR:
  - Set has priority over ERR_CLR in the same cycle.
  - ERR_CLR clears only when no new error occurs that cycle.
- Mid-burst reset: all state returns to reset values immediately. A partially sent burst is not completed; the far side must be reset with it.
- AWVALID/WVALID with X while not ready must not corrupt state.

Test Plan:
- Single beat: AWADDR=0x1000, AWLEN=0, AWID=3, then WDATA=0xDEADBEEF, WSTRB=0xF, WLAST=1, O_READY=1 -> two words, one per cycle. Header has bit49=1 and decodes to id 3 / addr 0x1000 / len 0. Data word has bit49=0, last=1, data 0xDEADBEEF. ERR=0.
- Backpressure: AWLEN=3, 4 beats, O_READY toggled 1,0,0,1,... -> O_DATA stays stable while stalled. Exactly 5 words, in order. Only the 4th data word has last=1. WREADY=0 whenever O_VALID=1 and O_READY=0.
- Early WLAST: AWLEN=3, WLAST=1 on beat 2 -> 2 data words, second with last=1. ERR=1. The next AW is accepted normally.
- Late WLAST: AWLEN=1, 4 beats with WLAST only on beat 4 -> 2 data words, second with forced last=1. Beats 3-4 consumed and dropped. ERR=1. ERR_CLR pulse -> ERR=0.
- Max length plus back-to-back: AWLEN=255, then immediately AWLEN=0, O_READY=1 -> 256 data words, then header 2 with no gap cycle. Total 259 words in 259 consecutive cycles after the first load.
- Reset mid-burst: assert WRESETn=0 after beat 5 of an AWLEN=15 burst -> O_VALID=0, AWREADY=0, WREADY=0 during reset. After release the FSM is in IDLE and AWREADY=1.
